// File: rtl/clint_mtimer_ext.sv
// rtl/clint_mtimer_ext.sv - core-local interruptor: 64-bit mtime, per-hart mtimecmp, msip and ssip
// Timebase is either a synchronised RTC edge or a clk_i prescaler; single-cycle register port.
module clint_mtimer_ext #(
  parameter int unsigned NR_HARTS    = 1,
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned RTC_MODE    = 1,
  parameter int unsigned PRESCALE_W  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    rtc_i,
  input  logic                    req_i,
  input  logic                    we_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  output logic                    rvalid_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    err_o,
  output logic [63:0]             mtime_o,
  output logic [NR_HARTS-1:0]     timer_irq_o,
  output logic [NR_HARTS-1:0]     msip_o,
  output logic [NR_HARTS-1:0]     ssip_o
);

  logic [63:0]            mtime_q, mtime_d;
  logic [63:0]            mtimecmp_q [NR_HARTS];
  logic [63:0]            mtimecmp_d [NR_HARTS];
  logic [NR_HARTS-1:0]    msip_q, msip_d, ssip_q, ssip_d, irq_q, irq_d;
  logic [PRESCALE_W-1:0]  prescale_q, prescale_d, cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] rtc_sync_q, rtc_sync_d;
  logic                   rtc_prev_q, rtc_prev_d;
  logic                   rvalid_q, rvalid_d, err_q, err_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d, rsel;

  logic [31:0] addr, msip_idx, cmp_idx, ssip_idx, wd32;
  logic [63:0] wd64, rd64;
  logic [7:0]  be64;
  logic [3:0]  be32;
  logic        msip_hit, cmp_hit, mtime_hit, ssip_hit, presc_hit, hit, aligned, wr;
  logic        presc_wr, mtime_wr, tick, rtc_tick, presc_tick;

  function automatic logic [63:0] merge64(input logic [63:0] o, input logic [63:0] n,
                                          input logic [7:0] be);
    logic [63:0] r;
    r = o;
    for (int b = 0; b < 8; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] merge32(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  function automatic logic [63:0] lane32(input logic [31:0] v, input logic hi);
    return hi ? {v, 32'b0} : {32'b0, v};
  endfunction

  assign addr = 32'(addr_i);

  // Everything is viewed as a 64-bit word; on a 32-bit bus addr[2] picks the half.
  if (DATA_WIDTH == 64) begin : g_dw64
    assign wd64 = wdata_i;
    assign be64 = be_i;
    assign rsel = rd64;
  end else begin : g_dw32
    assign wd64 = {wdata_i, wdata_i};
    assign be64 = addr[2] ? {be_i, 4'b0} : {4'b0, be_i};
    assign rsel = addr[2] ? rd64[63:32] : rd64[31:0];
  end

  assign wd32 = addr[2] ? wd64[63:32] : wd64[31:0];
  assign be32 = addr[2] ? be64[7:4] : be64[3:0];

  always_comb begin
    msip_idx  = addr >> 2;
    cmp_idx   = (addr - 32'h4000) >> 3;
    ssip_idx  = (addr - 32'hC000) >> 2;
    presc_hit = (addr[31:2] == 30'(32'hD000 >> 2));
    msip_hit  = addr < 32'(4 * NR_HARTS);
    cmp_hit   = (addr >= 32'h4000) && (addr < 32'h4000 + 32'(8 * NR_HARTS));
    mtime_hit = (addr >= 32'hBFF8) && (addr < 32'hC000);
    ssip_hit  = (addr >= 32'hC000) && (addr < 32'hC000 + 32'(4 * NR_HARTS)) && !presc_hit;
    hit       = msip_hit | cmp_hit | mtime_hit | ssip_hit | presc_hit;
    if (cmp_hit || mtime_hit) aligned = (DATA_WIDTH == 64) ? (addr[2:0] == 3'b0) : (addr[1:0] == 2'b0);
    else                      aligned = (addr[1:0] == 2'b0);
    err_d     = req_i & ~(hit & aligned);
    wr        = req_i & we_i & hit & aligned;
    presc_wr  = wr & presc_hit;
    mtime_wr  = wr & mtime_hit & (|be64);
    rvalid_d  = req_i;

    rd64   = '0;
    msip_d = msip_q;
    ssip_d = ssip_q;
    for (int i = 0; i < NR_HARTS; i++) begin
      if (msip_hit && msip_idx == 32'(i)) begin
        rd64 = lane32({31'b0, msip_q[i]}, addr[2]);
        if (wr && be32[0]) msip_d[i] = wd32[0];
      end
      if (ssip_hit && ssip_idx == 32'(i)) begin
        rd64 = lane32({31'b0, ssip_q[i]}, addr[2]);
        if (wr && be32[0]) ssip_d[i] = wd32[0];
      end
      mtimecmp_d[i] = mtimecmp_q[i];
      if (cmp_hit && cmp_idx == 32'(i)) begin
        rd64 = mtimecmp_q[i];
        if (wr) mtimecmp_d[i] = merge64(mtimecmp_q[i], wd64, be64);
      end
      irq_d[i] = (mtime_q >= mtimecmp_q[i]);
    end
    if (mtime_hit) rd64 = mtime_q;
    if (presc_hit) rd64 = lane32(32'(prescale_q), addr[2]);

    rdata_d = (req_i && !we_i && !err_d) ? rsel : '0;

    // Prescaler: count 0..P, tick on P; a PRESCALE write restarts it without ticking.
    prescale_d = presc_wr ? PRESCALE_W'(merge32(32'(prescale_q), wd32, be32)) : prescale_q;
    presc_tick = (cnt_q == prescale_q) && !presc_wr;
    if (presc_wr || cnt_q == prescale_q) cnt_d = '0;
    else                                 cnt_d = cnt_q + PRESCALE_W'(1);

    rtc_sync_d = {rtc_sync_q[SYNC_STAGES-2:0], rtc_i};
    rtc_prev_d = rtc_sync_q[SYNC_STAGES-1];
    rtc_tick   = rtc_sync_q[SYNC_STAGES-1] & ~rtc_prev_q;
    tick       = (RTC_MODE != 0) ? rtc_tick : presc_tick;

    if (mtime_wr)  mtime_d = merge64(mtime_q, wd64, be64);
    else if (tick) mtime_d = mtime_q + 64'd1;
    else           mtime_d = mtime_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mtime_q    <= '0;
      for (int i = 0; i < NR_HARTS; i++) mtimecmp_q[i] <= '0;
      msip_q     <= '0;
      ssip_q     <= '0;
      irq_q      <= '0;
      prescale_q <= '0;
      cnt_q      <= '0;
      rtc_sync_q <= '0;
      rtc_prev_q <= 1'b0;
      rvalid_q   <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      mtime_q    <= mtime_d;
      for (int i = 0; i < NR_HARTS; i++) mtimecmp_q[i] <= mtimecmp_d[i];
      msip_q     <= msip_d;
      ssip_q     <= ssip_d;
      irq_q      <= irq_d;
      prescale_q <= prescale_d;
      cnt_q      <= cnt_d;
      rtc_sync_q <= rtc_sync_d;
      rtc_prev_q <= rtc_prev_d;
      rvalid_q   <= rvalid_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
    end
  end

  assign rvalid_o    = rvalid_q;
  assign err_o       = err_q;
  assign rdata_o     = rdata_q;
  assign mtime_o     = mtime_q;
  assign timer_irq_o = irq_q;
  assign msip_o      = msip_q;
  assign ssip_o      = ssip_q;

endmodule

// File: tb/tb_clint_mtimer_ext.sv
// tb/tb_clint_mtimer_ext.sv - directed bench for clint_mtimer_ext
// Instance a: 64-bit bus, 1 hart, prescaler timebase. Instance b: 32-bit bus, 2 harts, RTC timebase.
module tb_clint_mtimer_ext;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rstn, a_req, a_we, a_rvalid, a_err;
  logic [15:0] a_addr;
  logic [63:0] a_wdata, a_rdata, a_mtime;
  logic [7:0]  a_be;
  logic [0:0]  a_irq, a_msip, a_ssip;

  logic        b_rstn, b_rtc, b_req, b_we, b_rvalid, b_err;
  logic [15:0] b_addr;
  logic [31:0] b_wdata, b_rdata;
  logic [63:0] b_mtime;
  logic [3:0]  b_be;
  logic [1:0]  b_irq, b_msip, b_ssip;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] rd;
  logic [31:0] rd32;
  logic        er, rv;

  clint_mtimer_ext #(.NR_HARTS(1), .DATA_WIDTH(64), .ADDR_WIDTH(16), .RTC_MODE(0),
                     .PRESCALE_W(16), .SYNC_STAGES(2)) u_a (
    .clk_i(clk), .rst_ni(a_rstn), .rtc_i(1'b0), .req_i(a_req), .we_i(a_we),
    .addr_i(a_addr), .wdata_i(a_wdata), .be_i(a_be), .rvalid_o(a_rvalid),
    .rdata_o(a_rdata), .err_o(a_err), .mtime_o(a_mtime), .timer_irq_o(a_irq),
    .msip_o(a_msip), .ssip_o(a_ssip)
  );

  clint_mtimer_ext #(.NR_HARTS(2), .DATA_WIDTH(32), .ADDR_WIDTH(16), .RTC_MODE(1),
                     .PRESCALE_W(16), .SYNC_STAGES(2)) u_b (
    .clk_i(clk), .rst_ni(b_rstn), .rtc_i(b_rtc), .req_i(b_req), .we_i(b_we),
    .addr_i(b_addr), .wdata_i(b_wdata), .be_i(b_be), .rvalid_o(b_rvalid),
    .rdata_o(b_rdata), .err_o(b_err), .mtime_o(b_mtime), .timer_irq_o(b_irq),
    .msip_o(b_msip), .ssip_o(b_ssip)
  );

  // Called at a negedge; returns at the next negedge with the response sampled.
  task automatic a_acc(input logic we, input logic [15:0] ad, input logic [63:0] wd,
                       input logic [7:0] be, output logic [63:0] r, output logic e, output logic v);
    a_req = 1'b1; a_we = we; a_addr = ad; a_wdata = wd; a_be = be;
    @(negedge clk);
    r = a_rdata; e = a_err; v = a_rvalid;
    a_req = 1'b0; a_we = 1'b0;
  endtask

  task automatic b_acc(input logic we, input logic [15:0] ad, input logic [31:0] wd,
                       input logic [3:0] be, output logic [31:0] r, output logic e, output logic v);
    b_req = 1'b1; b_we = we; b_addr = ad; b_wdata = wd; b_be = be;
    @(negedge clk);
    r = b_rdata; e = b_err; v = b_rvalid;
    b_req = 1'b0; b_we = 1'b0;
  endtask

  task automatic test_reset;
    a_rstn = 1'b0; b_rstn = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (a_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid got %b want 0", a_rvalid); end
    n_checks++; if (a_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", a_err); end
    n_checks++; if (a_rdata !== 64'h0) begin n_fail++; $display("FAIL reset_rdata got %h want 0", a_rdata); end
    n_checks++; if (a_mtime !== 64'h0) begin n_fail++; $display("FAIL reset_mtime got %h want 0", a_mtime); end
    n_checks++; if (a_irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b want 0", a_irq); end
    a_rstn = 1'b1; b_rstn = 1'b1;
    a_acc(1'b0, 16'hBFF8, 64'h0, 8'hFF, rd, er, rv);
    n_checks++; if (rv !== 1'b1) begin n_fail++; $display("FAIL first_rvalid got %b want 1", rv); end
    n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL first_err got %b want 0", er); end
    n_checks++; if (rd !== 64'h0) begin n_fail++; $display("FAIL first_rdata got %h want 0", rd); end
    n_checks++; if (a_mtime !== 64'd1) begin n_fail++; $display("FAIL count_1 got %h want 1", a_mtime); end
    n_checks++; if (a_irq !== 1'b1) begin n_fail++; $display("FAIL irq_after_reset got %b want 1", a_irq); end
    @(negedge clk);
    n_checks++; if (a_mtime !== 64'd2) begin n_fail++; $display("FAIL count_2 got %h want 2", a_mtime); end
    n_checks++; if (a_rvalid !== 1'b0) begin n_fail++; $display("FAIL rvalid_idle got %b want 0", a_rvalid); end
  endtask

  task automatic test_prescale;
    a_acc(1'b1, 16'hD000, 64'd3, 8'hFF, rd, er, rv);
    a_acc(1'b1, 16'h4000, 64'd10, 8'hFF, rd, er, rv);
    a_acc(1'b1, 16'hBFF8, 64'd0, 8'hFF, rd, er, rv);
    n_checks++; if (a_mtime !== 64'd0) begin n_fail++; $display("FAIL presc_load got %h want 0", a_mtime); end
    repeat (5) @(negedge clk);
    n_checks++; if (a_mtime !== 64'd1) begin n_fail++; $display("FAIL presc_t1 got %h want 1", a_mtime); end
    @(negedge clk);
    n_checks++; if (a_mtime !== 64'd2) begin n_fail++; $display("FAIL presc_t2 got %h want 2", a_mtime); end
    repeat (32) @(negedge clk);
    n_checks++; if (a_mtime !== 64'd10) begin n_fail++; $display("FAIL presc_t10 got %h want 10", a_mtime); end
    n_checks++; if (a_irq !== 1'b0) begin n_fail++; $display("FAIL irq_lag got %b want 0", a_irq); end
    @(negedge clk);
    n_checks++; if (a_irq !== 1'b1) begin n_fail++; $display("FAIL irq_rise got %b want 1", a_irq); end
    a_acc(1'b1, 16'h4000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, rd, er, rv);
    n_checks++; if (a_irq !== 1'b1) begin n_fail++; $display("FAIL irq_hold got %b want 1", a_irq); end
    @(negedge clk);
    n_checks++; if (a_irq !== 1'b0) begin n_fail++; $display("FAIL irq_fall got %b want 0", a_irq); end
  endtask

  task automatic test_wrap;
    a_acc(1'b1, 16'hD000, 64'd0, 8'hFF, rd, er, rv);
    a_acc(1'b1, 16'hBFF8, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, rd, er, rv);
    n_checks++; if (a_mtime !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL wrap_load got %h want all ones", a_mtime); end
    @(negedge clk);
    n_checks++; if (a_mtime !== 64'h0) begin n_fail++; $display("FAIL wrap_zero got %h want 0", a_mtime); end
    a_acc(1'b1, 16'hBFF8, 64'd5, 8'hFF, rd, er, rv);
    n_checks++; if (a_mtime !== 64'd5) begin n_fail++; $display("FAIL write_prio got %h want 5", a_mtime); end
    @(negedge clk);
    n_checks++; if (a_mtime !== 64'd6) begin n_fail++; $display("FAIL after_prio got %h want 6", a_mtime); end
    a_acc(1'b1, 16'hBFF8, 64'h0000_0000_0000_AB00, 8'h02, rd, er, rv);
    n_checks++; if (a_mtime !== 64'hAB06) begin n_fail++; $display("FAIL mtime_be got %h want ab06", a_mtime); end
  endtask

  task automatic test_back_to_back;
    a_acc(1'b0, 16'h4000, 64'h0, 8'h00, rd, er, rv);
    n_checks++; if (rv !== 1'b1 || er !== 1'b0 || rd !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      n_fail++; $display("FAIL b2b_cmp got v%b e%b %h want v1 e0 all ones", rv, er, rd); end
    a_acc(1'b0, 16'hD000, 64'h0, 8'h00, rd, er, rv);
    n_checks++; if (rv !== 1'b1 || er !== 1'b0 || rd !== 64'h0) begin
      n_fail++; $display("FAIL b2b_presc got v%b e%b %h want v1 e0 0", rv, er, rd); end
    a_acc(1'b0, 16'h4008, 64'h0, 8'h00, rd, er, rv);
    n_checks++; if (rv !== 1'b1 || er !== 1'b1 || rd !== 64'h0) begin
      n_fail++; $display("FAIL b2b_unmapped got v%b e%b %h want v1 e1 0", rv, er, rd); end
    a_acc(1'b0, 16'hBFFC, 64'h0, 8'h00, rd, er, rv);
    n_checks++; if (rv !== 1'b1 || er !== 1'b1) begin
      n_fail++; $display("FAIL b2b_misalign got v%b e%b want v1 e1", rv, er); end
  endtask

  task automatic test_dw32;
    b_acc(1'b1, 16'h4008, 32'h1234, 4'hF, rd32, er, rv);
    b_acc(1'b1, 16'h400C, 32'h1, 4'hF, rd32, er, rv);
    b_acc(1'b0, 16'h4008, 32'h0, 4'h0, rd32, er, rv);
    n_checks++; if (rd32 !== 32'h1234) begin n_fail++; $display("FAIL dw32_lo got %h want 1234", rd32); end
    b_acc(1'b0, 16'h400C, 32'h0, 4'h0, rd32, er, rv);
    n_checks++; if (rd32 !== 32'h1) begin n_fail++; $display("FAIL dw32_hi got %h want 1", rd32); end
    b_acc(1'b1, 16'h4008, 32'hFF, 4'b0001, rd32, er, rv);
    b_acc(1'b0, 16'h4008, 32'h0, 4'h0, rd32, er, rv);
    n_checks++; if (rd32 !== 32'h12FF) begin n_fail++; $display("FAIL dw32_be got %h want 12ff", rd32); end
    b_acc(1'b0, 16'h4010, 32'h0, 4'h0, rd32, er, rv);
    n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL dw32_range got %b want 1", er); end
    n_checks++; if (b_irq !== 2'b01) begin n_fail++; $display("FAIL dw32_irq got %b want 01", b_irq); end
  endtask

  task automatic test_soft_irq;
    b_acc(1'b1, 16'h0004, 32'h1, 4'hF, rd32, er, rv);
    n_checks++; if (b_msip !== 2'b10) begin n_fail++; $display("FAIL msip got %b want 10", b_msip); end
    b_acc(1'b1, 16'hC000, 32'h1, 4'hF, rd32, er, rv);
    n_checks++; if (b_ssip !== 2'b01) begin n_fail++; $display("FAIL ssip got %b want 01", b_ssip); end
    b_acc(1'b1, 16'h0008, 32'h1, 4'hF, rd32, er, rv);
    n_checks++; if (er !== 1'b1 || b_msip !== 2'b10 || b_ssip !== 2'b01) begin
      n_fail++; $display("FAIL bad_write got e%b msip%b ssip%b want e1 10 01", er, b_msip, b_ssip); end
    b_acc(1'b0, 16'h4003, 32'h0, 4'h0, rd32, er, rv);
    n_checks++; if (er !== 1'b1 || rd32 !== 32'h0) begin
      n_fail++; $display("FAIL misalign_read got e%b %h want e1 0", er, rd32); end
    b_acc(1'b1, 16'hC004, 32'h1, 4'hF, rd32, er, rv);
    b_acc(1'b1, 16'hC000, 32'h0, 4'hF, rd32, er, rv);
    n_checks++; if (b_ssip !== 2'b10) begin n_fail++; $display("FAIL ssip_clear got %b want 10", b_ssip); end
    b_acc(1'b0, 16'hC004, 32'h0, 4'h0, rd32, er, rv);
    n_checks++; if (rd32 !== 32'h1) begin n_fail++; $display("FAIL ssip_read got %h want 1", rd32); end
  endtask

  task automatic test_rtc;
    for (int k = 0; k < 40; k++) begin
      if (k == 2) begin n_checks++; if (b_mtime !== 64'd0) begin n_fail++; $display("FAIL rtc_k2 got %h want 0", b_mtime); end end
      if (k == 3) begin n_checks++; if (b_mtime !== 64'd1) begin n_fail++; $display("FAIL rtc_k3 got %h want 1", b_mtime); end end
      if (k == 12) begin n_checks++; if (b_mtime !== 64'd1) begin n_fail++; $display("FAIL rtc_k12 got %h want 1", b_mtime); end end
      if (k == 13) begin n_checks++; if (b_mtime !== 64'd2) begin n_fail++; $display("FAIL rtc_k13 got %h want 2", b_mtime); end end
      if (k == 39) begin n_checks++; if (b_mtime !== 64'd4) begin n_fail++; $display("FAIL rtc_k39 got %h want 4", b_mtime); end end
      b_rtc = ((k % 10) < 5);
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid;
    b_req = 1'b1; b_we = 1'b0; b_addr = 16'hBFF8; b_be = 4'h0;
    @(posedge clk);
    #1;
    n_checks++; if (b_rvalid !== 1'b1 || b_mtime !== 64'd4) begin
      n_fail++; $display("FAIL pre_reset got v%b %h want v1 4", b_rvalid, b_mtime); end
    b_rstn = 1'b0;
    #1;
    n_checks++; if (b_rvalid !== 1'b0 || b_mtime !== 64'd0 || b_msip !== 2'b00) begin
      n_fail++; $display("FAIL mid_reset got v%b %h msip%b want v0 0 00", b_rvalid, b_mtime, b_msip); end
    @(negedge clk);
    b_req = 1'b0;
    b_rstn = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    a_rstn = 1'b0; a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0; a_be = '0;
    b_rstn = 1'b0; b_rtc = 1'b0; b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0; b_be = '0;
    test_reset;
    test_prescale;
    test_wrap;
    test_back_to_back;
    test_dw32;
    test_soft_irq;
    test_rtc;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
